bit_serial_adder: RTL and testbench

- Multi-cycle N-bit adder built around one instance of the existing 1-bit full adder `fa` (ports co, s, ci, x, y).
- Feeds `fa` one operand bit pair per clock, LSB first.
- Registers `fa.co` as the next cycle's carry-in and shifts `fa.s` into a result register.
- Sits between a simple start/done controller and any consumer of an N-bit sum. It is the area-cheap alternative to a ripple chain of N `fa` instances.

---
 rtl/bit_serial_adder.sv | 212 +++++++++++++++++++++
 tb/tb_bit_serial_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial N-bit adder: one full adder consumes an operand bit pair per clock, LSB first.
// Optional signed-overflow output is enabled by defining BIT_SERIAL_ADDER_OVF_EN.

module bit_serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] r,
  output logic         co
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CntW = $clog2(N);
  localparam int unsigned SumW = N - 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]    xs_q, xs_d;
  logic [N-1:0]    ys_q, ys_d;
  // Only N-1 partial sum bits are ever stored; the last bit goes straight into r.
  logic [SumW-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    r_q, r_d;
  logic            co_q, co_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;
  logic last_bit;

  fa u_fa (
    .co (fa_co),
    .s  (fa_s),
    .ci (carry_q),
    .x  (xs_q[0]),
    .y  (ys_q[0])
  );

  assign last_bit = (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (last_bit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next-state
  always_comb begin
    xs_d    = xs_q;
    ys_d    = ys_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    co_d    = co_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          xs_d    = x;
          ys_d    = y;
          sum_d   = '0;
          carry_d = ci;
          cnt_d   = '0;
        end
      end
      StRun: begin
        xs_d    = xs_q >> 1;
        ys_d    = ys_q >> 1;
        sum_d   = SumW'({fa_s, sum_q} >> 1);
        carry_d = fa_co;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          r_d  = {fa_s, sum_q};
          co_d = fa_co;
`ifdef BIT_SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB position on this edge
          ovf_d = carry_q ^ fa_co;
`endif
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q    <= '0;
      ys_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      co_q    <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      co_q    <= co_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign r  = r_q;
  assign co = co_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`endif

  // Sanity properties on the controller
  property p_done_one_cycle;
    @(posedge clk) disable iff (!rst_n) done |=> !done;
  endproperty
  assert property (p_done_one_cycle);

  property p_busy_done_exclusive;
    @(posedge clk) disable iff (!rst_n) !(busy && done);
  endproperty
  assert property (p_busy_done_exclusive);

  property p_result_stable_in_run;
    @(posedge clk) disable iff (!rst_n) (busy && !last_bit) |=> $stable(r) && $stable(co);
  endproperty
  assert property (p_result_stable_in_run);

endmodule

// 1-bit full adder used as the serial arithmetic element.
module fa (
  output logic co,
  output logic s,
  input  logic ci,
  input  logic x,
  input  logic y
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: vector table plus scoreboard, with hand-written corner sequences.
module tb_bit_serial_adder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         ci = 1'b0;
  logic         busy;
  logic         done;
  logic [N-1:0] r;
  logic         co;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .co    (co)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         ci;
    logic [N-1:0] r;
    logic         co;
    logic         ovf;
    logic         scramble;
  } vec_t;

  typedef struct {
    logic [N-1:0] r;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    vec_t v;
    logic [N:0] full;
    full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    v.x = a;
    v.y = b;
    v.ci = c;
    v.r = full[N-1:0];
    v.co = full[N];
    v.ovf = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
    v.scramble = 1'b0;
    return v;
  endfunction

  task automatic check_result(input string tag, input exp_t e);
    check({tag, "_r"}, r, e.r);
    check({tag, "_co"}, co, e.co);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, e.ovf);
`endif
  endtask

  task automatic run_add(input vec_t v, input string tag);
    int k;
    int busy_cnt;
    bit seen;
    exp_t e;
    @(negedge clk);
    x = v.x;
    y = v.y;
    ci = v.ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.r = v.r;
    e.co = v.co;
    e.ovf = v.ovf;
    sb.push_back(e);
    if (v.scramble) begin
      x = '1;
      y = '1;
      ci = ~ci;
    end
    k = 0;
    busy_cnt = 0;
    seen = 0;
    while (!seen && k < 4 * N) begin
      @(negedge clk);
      k++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check_result(tag, e);
      check({tag, "_latency"}, k, N + 1);
      check({tag, "_busy_cycles"}, busy_cnt, N);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      repeat (2) @(negedge clk);
      check_result({tag, "_hold"}, e);
    end
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    exp_t e;
    int done_cnt;
    int first_done;
    int second_done;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_r", r, 0);
    check("rst_co", co, 0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_done", done, 0);

    for (int i = 0; i < 7; i++) begin
      run_add(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      v = model(N'($urandom), N'($urandom), 1'($urandom));
      v.scramble = 1'($urandom);
      run_add(v, $sformatf("rnd%0d", i));
    end

    // start re-pulsed during RUN must be ignored
    @(negedge clk);
    x = 8'h10;
    y = 8'h20;
    ci = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    v = model(8'h10, 8'h20, 1'b0);
    e.r = v.r;
    e.co = v.co;
    e.ovf = v.ovf;
    sb.push_back(e);
    repeat (3) @(negedge clk);
    x = 8'hFF;
    y = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 3 * N; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_result("repulse", e);
        end
      end
    end
    check("repulse_done_count", done_cnt, 1);
    check("repulse_hold_r", r, 8'h30);

    // Asynchronous reset mid-RUN abandons the add
    @(negedge clk);
    x = 8'hAA;
    y = 8'h55;
    ci = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_r", r, 0);
    check("arst_co", co, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 3 * N; k++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("arst_no_activity", done_cnt, 0);

    // start held high: back-to-back adds with one IDLE cycle between
    @(negedge clk);
    x = 8'h01;
    y = 8'h02;
    ci = 1'b0;
    start = 1'b1;
    first_done = -1;
    second_done = -1;
    for (int k = 0; k < 3 * N + 10; k++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
    end
    start = 1'b0;
    check("b2b_second_seen", (second_done >= 0), 1);
    check("b2b_gap", second_done - first_done, N + 2);
    check("b2b_r", r, 8'h03);
    repeat (2 * N + 4) @(negedge clk);
    check("b2b_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
